// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter and the pipeline it serves.
package lc3b_types;

  localparam int LC3B_WORD_WIDTH  = 16;
  localparam int LC3B_WMASK_WIDTH = LC3B_WORD_WIDTH / 8;

  typedef logic [LC3B_WORD_WIDTH-1:0]  lc3b_word;
  typedef logic [LC3B_WMASK_WIDTH-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } lc3b_arb_state;

  typedef enum logic {
    ARB_PORT_I,
    ARB_PORT_D
  } lc3b_arb_port;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the
// instruction-fetch port (0) and the data port (1).
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read_0,
  input  logic [ADDR_WIDTH-1:0] mem_address_0,
  output logic [DATA_WIDTH-1:0] mem_rdata_0,
  output logic                  mem_resp_0,
  input  logic                  mem_read_1,
  input  logic                  mem_write_1,
  input  logic [BE_WIDTH-1:0]   mem_byte_enable_1,
  input  logic [ADDR_WIDTH-1:0] mem_address_1,
  input  logic [DATA_WIDTH-1:0] mem_wdata_1,
  output logic [DATA_WIDTH-1:0] mem_rdata_1,
  output logic                  mem_resp_1,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [BE_WIDTH-1:0]   pmem_byte_enable,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  busy
);

  lc3b_arb_state state, state_next;
  lc3b_arb_port  last_grant;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;
  logic                  lat_write;

  logic req_i, req_d, grant_i, grant_d, complete;

  // On a tie the port that did not win last time gets the grant.
  assign req_i    = mem_read_0;
  assign req_d    = mem_read_1 | mem_write_1;
  assign grant_d  = req_d && (!req_i || (last_grant == ARB_PORT_I));
  assign grant_i  = req_i && !grant_d;
  assign complete = (state != ARB_IDLE) && pmem_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_write  <= 1'b0;
      last_grant <= ARB_PORT_I;
    end else begin
      if (state == ARB_IDLE && grant_i) begin
        lat_addr  <= mem_address_0;
        lat_wdata <= '0;
        lat_be    <= '1;
        lat_write <= 1'b0;
      end else if (state == ARB_IDLE && grant_d) begin
        lat_addr  <= mem_address_1;
        lat_wdata <= mem_write_1 ? mem_wdata_1 : '0;
        lat_be    <= mem_write_1 ? mem_byte_enable_1 : '1;
        lat_write <= mem_write_1;
      end
      if (complete)
        last_grant <= (state == ARB_SERVE_I) ? ARB_PORT_I : ARB_PORT_D;
    end
  end

  // Downstream signals come only from the latch bank, so requesters may change freely mid-access.
  always_comb begin
    state_next       = state;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    mem_resp_0       = 1'b0;
    mem_resp_1       = 1'b0;
    mem_rdata_0      = '0;
    mem_rdata_1      = '0;
    busy             = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_i)      state_next = ARB_SERVE_I;
        else if (grant_d) state_next = ARB_SERVE_D;
      end
      ARB_SERVE_I: begin
        busy         = 1'b1;
        pmem_read    = 1'b1;
        pmem_address = lat_addr;
        if (pmem_resp) begin
          mem_resp_0  = 1'b1;
          mem_rdata_0 = pmem_rdata;
          state_next  = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        busy         = 1'b1;
        pmem_read    = !lat_write;
        pmem_write   = lat_write;
        pmem_address = lat_addr;
        if (lat_write) begin
          pmem_wdata       = lat_wdata;
          pmem_byte_enable = lat_be;
        end
        if (pmem_resp) begin
          mem_resp_1  = 1'b1;
          mem_rdata_1 = pmem_rdata;
          state_next  = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_read_1 && mem_write_1));

  a_no_resp_when_idle: assert property (@(posedge clk) disable iff (!reset_n)
    !(pmem_resp && state == ARB_IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read_0;
  logic [15:0] mem_address_0;
  logic [15:0] mem_rdata_0;
  logic        mem_resp_0;
  logic        mem_read_1;
  logic        mem_write_1;
  logic [1:0]  mem_byte_enable_1;
  logic [15:0] mem_address_1;
  logic [15:0] mem_wdata_1;
  logic [15:0] mem_rdata_1;
  logic        mem_resp_1;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;

  mem_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_read_0        (mem_read_0),
    .mem_address_0     (mem_address_0),
    .mem_rdata_0       (mem_rdata_0),
    .mem_resp_0        (mem_resp_0),
    .mem_read_1        (mem_read_1),
    .mem_write_1       (mem_write_1),
    .mem_byte_enable_1 (mem_byte_enable_1),
    .mem_address_1     (mem_address_1),
    .mem_wdata_1       (mem_wdata_1),
    .mem_rdata_1       (mem_rdata_1),
    .mem_resp_1        (mem_resp_1),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_byte_enable  (pmem_byte_enable),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd0, input logic [15:0] a0, input logic rd1,
                               input logic wr1, input logic [1:0] be1,
                               input logic [15:0] a1, input logic [15:0] wd1);
    mem_read_0        = rd0;
    mem_address_0     = a0;
    mem_read_1        = rd1;
    mem_write_1       = wr1;
    mem_byte_enable_1 = be1;
    mem_address_1     = a1;
    mem_wdata_1       = wd1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Caller is at the negedge of a serve cycle; the downstream completes now.
  task automatic respondNow(input logic [15:0] rdata);
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    #1;
  endtask

  task automatic endResponse();
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0000;
    #1;
  endtask

  initial begin
    int lastPort;
    int expPort;
    int iGrants;

    reset_n    = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0000;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);

    // Reset state
    @(negedge clk);
    checkOutput("rst_pmem_read", pmem_read, 0);
    checkOutput("rst_pmem_write", pmem_write, 0);
    checkOutput("rst_pmem_address", pmem_address, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_resp_0", mem_resp_0, 0);
    checkOutput("rst_resp_1", mem_resp_1, 0);

    // I-port read with a 3-cycle downstream
    reset_n = 1'b1;
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("i_pmem_read_c1", pmem_read, 1);
    checkOutput("i_pmem_address", pmem_address, 16'h0010);
    checkOutput("i_busy", busy, 1);
    checkOutput("i_resp_early", mem_resp_0, 0);
    @(negedge clk);
    checkOutput("i_pmem_read_c2", pmem_read, 1);
    @(negedge clk);
    checkOutput("i_pmem_read_c3", pmem_read, 1);
    respondNow(16'h1234);
    applyStimulus(1'b0, 16'h0010, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    checkOutput("i_resp_0", mem_resp_0, 1);
    checkOutput("i_rdata_0", mem_rdata_0, 16'h1234);
    checkOutput("i_resp_1", mem_resp_1, 0);
    checkOutput("i_rdata_1", mem_rdata_1, 0);
    endResponse();
    checkOutput("i_resp_0_drop", mem_resp_0, 0);
    checkOutput("i_idle_busy", busy, 0);
    checkOutput("i_idle_read", pmem_read, 0);

    // Tie right after reset: D first, one idle cycle, then I
    applyReset();
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h3000, 16'h0);
    @(negedge clk);
    checkOutput("tie_first_addr", pmem_address, 16'h3000);
    checkOutput("tie_first_read", pmem_read, 1);
    checkOutput("tie_first_wdata", pmem_wdata, 0);
    respondNow(16'hAAAA);
    checkOutput("tie_first_resp_1", mem_resp_1, 1);
    checkOutput("tie_first_rdata_1", mem_rdata_1, 16'hAAAA);
    checkOutput("tie_first_resp_0", mem_resp_0, 0);
    checkOutput("tie_first_rdata_0", mem_rdata_0, 0);
    mem_read_1 = 1'b0;
    endResponse();
    checkOutput("tie_gap_busy", busy, 0);
    @(negedge clk);
    checkOutput("tie_second_addr", pmem_address, 16'h0000);
    checkOutput("tie_second_read", pmem_read, 1);
    respondNow(16'h5555);
    checkOutput("tie_second_resp_0", mem_resp_0, 1);
    checkOutput("tie_second_rdata_0", mem_rdata_0, 16'h5555);
    checkOutput("tie_second_resp_1", mem_resp_1, 0);
    mem_read_1 = 1'b1;
    endResponse();
    checkOutput("tie_second_gap_busy", busy, 0);

    // Both requests held for 10 transactions: strict alternation
    lastPort = 0;
    iGrants  = 0;
    for (int i = 0; i < 10; i++) begin
      expPort = (lastPort == 0) ? 1 : 0;
      @(negedge clk);
      checkOutput($sformatf("rr_busy_%0d", i), busy, 1);
      checkOutput($sformatf("rr_addr_%0d", i), pmem_address, (expPort == 1) ? 16'h3000 : 16'h0000);
      respondNow(16'h1000 + 16'(i));
      if (expPort == 1) begin
        checkOutput($sformatf("rr_resp_d_%0d", i), mem_resp_1, 1);
        checkOutput($sformatf("rr_other_%0d", i), mem_resp_0, 0);
        checkOutput($sformatf("rr_rdata_%0d", i), mem_rdata_1, 16'h1000 + 16'(i));
      end else begin
        checkOutput($sformatf("rr_resp_i_%0d", i), mem_resp_0, 1);
        checkOutput($sformatf("rr_other_%0d", i), mem_resp_1, 0);
        checkOutput($sformatf("rr_rdata_%0d", i), mem_rdata_0, 16'h1000 + 16'(i));
        if (mem_resp_0 === 1'b1) iGrants++;
      end
      lastPort = expPort;
      endResponse();
      checkOutput($sformatf("rr_gap_%0d", i), busy, 0);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    checkOutput("rr_i_grants", iGrants, 5);

    // D write with latched data; inputs change mid-access
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 2'b10, 16'h2002, 16'hBEEF);
    @(negedge clk);
    checkOutput("wr_pmem_write", pmem_write, 1);
    checkOutput("wr_pmem_read", pmem_read, 0);
    checkOutput("wr_address", pmem_address, 16'h2002);
    checkOutput("wr_wdata", pmem_wdata, 16'hBEEF);
    checkOutput("wr_be", pmem_byte_enable, 2'b10);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 2'b01, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("wr_hold_write", pmem_write, 1);
    checkOutput("wr_hold_wdata", pmem_wdata, 16'hBEEF);
    checkOutput("wr_hold_be", pmem_byte_enable, 2'b10);
    respondNow(16'h0000);
    checkOutput("wr_resp_1", mem_resp_1, 1);
    checkOutput("wr_resp_0", mem_resp_0, 0);
    endResponse();
    checkOutput("wr_idle_write", pmem_write, 0);

    // D read whose requester changes address mid-access
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 2'b00, 16'h4000, 16'h0);
    @(negedge clk);
    checkOutput("chg_addr_initial", pmem_address, 16'h4000);
    checkOutput("chg_read", pmem_read, 1);
    checkOutput("chg_wdata", pmem_wdata, 0);
    mem_address_1 = 16'h5000;
    @(negedge clk);
    checkOutput("chg_addr_held", pmem_address, 16'h4000);
    respondNow(16'h7777);
    checkOutput("chg_resp_1", mem_resp_1, 1);
    checkOutput("chg_rdata_1", mem_rdata_1, 16'h7777);
    mem_read_1 = 1'b0;
    endResponse();

    // Asynchronous reset in the middle of an I read, with a D read pending
    applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("ar_read", pmem_read, 1);
    checkOutput("ar_addr", pmem_address, 16'h0100);
    mem_read_1    = 1'b1;
    mem_address_1 = 16'h6000;
    @(negedge clk);
    checkOutput("ar_no_regrant", pmem_address, 16'h0100);
    #2;
    reset_n    = 1'b0;
    mem_read_0 = 1'b0;
    #1;
    checkOutput("ar_read_dropped", pmem_read, 0);
    checkOutput("ar_addr_cleared", pmem_address, 0);
    checkOutput("ar_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("ar_d_granted", pmem_read, 1);
    checkOutput("ar_d_addr", pmem_address, 16'h6000);
    respondNow(16'h9999);
    checkOutput("ar_d_resp", mem_resp_1, 1);
    mem_read_1 = 1'b0;
    endResponse();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
